fp_addsub: RTL
==============

# fp_addsub

Pipelined IEEE-754 single-precision adder/subtractor that consumes the floating-point multiplier's 32-bit products. In the butterfly/twiddle datapath it forms the complex-multiply sums, re = ar·br − ai·bi and im = ar·bi + ai·br. It is a fixed-latency streaming stage with a valid qualifier and no backpressure, matching the multiplier's free-running pipeline.

## Interface
- No parameters; width is fixed at 32 bits (binary32).
- clk  in  1  rising-edge clock shared with the multiplier.
- rst_n  in  1  asynchronous, active-low reset; clears all valid bits and outputs.
- in_valid  in  1  a, b and sub are sampled on this edge.
- a  in  32  operand A (sign/exp/mantissa 1/8/23).
- b  in  32  operand B.
- sub  in  1  1 selects A − B, 0 selects A + B.
- out_valid  out  1  c and flags are a new result this cycle.
- c  out  32  result.
- ovf  out  1  result overflowed to ±inf from finite operands.
- nan  out  1  result is the canonical NaN.
- zero  out  1  result is ±0.

## Operation
- Four-stage pipeline; the valid bit travels alongside the data.
- **S1 (unpack/swap):**
  - Register inputs; effective sign of B is b[31]^sub.
  - Exp 0 means zero (denormals flushed, mantissa ignored).
  - Exp 255 means inf/NaN.
  - Swap so that |A| ≥ |B|, comparing exponent first, then mantissa.
- **S2 (align):**
  - d = eA − eB.
  - Shift B's 24-bit mantissa (hidden 1) right by d into a 27-bit field carrying guard, round and sticky bits.
  - d ≥ 26 leaves sticky only.
- **S3 (add):** 28-bit add when signs match, subtract otherwise; result sign = sign of the larger operand.
- **S4 (normalize/pack):**
  - Carry out: shift right by 1 and increment exponent.
  - Otherwise: leading-zero count, shift left, decrement exponent.
  - Round (see Configuration), pack, register outputs.
- **Specials, resolved in S1 and carried as a tag:**
  - Any NaN input, or inf − inf (effective): c = 0x7FC00000, nan = 1.
  - inf ± finite: that inf.
  - Both zero: −0 only if both are effectively negative, else +0.
- Exact cancellation gives +0x00000000 with zero = 1.
- Final exponent ≥ 255 (including a rounding carry) gives ±0x7F800000 with ovf = 1.
- Final exponent ≤ 0 flushes to signed zero with zero = 1.
- Flags are mutually exclusive and valid only with out_valid.

## Timing
- Latency is exactly 4 cycles: inputs sampled at edge t produce c/out_valid registered at edge t+4.
- Throughput is one operation per cycle. Back-to-back and gapped streams are both legal, and output order equals input order.
- When out_valid = 0, c and the flags hold the last valid result. Data registers load only when their stage valid is 1.
- Reset values: out_valid = 0, c = 0x00000000, ovf = nan = zero = 0, and all internal valid bits = 0.
- Asserting rst_n mid-operation discards all in-flight operations; no out_valid pulse follows for them.
- Operands presented on the first edge after deassertion are processed normally.
- in_valid = 0 creates a bubble; the content of a/b/sub is don't-care.

## Configuration
- **FPADD_RNE_EN defined:**
  - Round to nearest, ties to even, using G/R/S.
  - A mantissa carry from rounding renormalizes; it may overflow to inf with ovf = 1.
- **FPADD_RNE_EN undefined:**
  - Truncate (round toward zero); G/R/S are dropped.
  - Output is bit-compatible with the multiplier's truncating normaliser.
- Latency is 4 cycles in both builds.

## Test plan
- a=0x3F800000, b=0x40000000, sub=0 at edge t → c=0x40400000, out_valid=1 at edge t+4 only, all flags 0.
- a=0x40400000, b=0x40400000, sub=1 → c=0x00000000, zero=1; a=0x00400000 (denormal), b=0x3F800000, sub=0 → c=0x3F800000.
- Back-to-back on three consecutive edges:
  - 0x3FC00000+0x3FC00000 → 0x40400000.
  - 0x7F7FFFFF+0x7F7FFFFF → 0x7F800000 with ovf=1.
  - 0x7F800000−0x7F800000 → 0x7FC00000 with nan=1.
  - Results appear on three consecutive output edges, in order.
- Rounding:
  - 0x3F800000+0x33C00000: RNE → 0x3F800001; truncate → 0x3F800000.
  - 0x3F800000+0x33800000 (tie) → 0x3F800000 in both builds.
- Reset mid-stream: in_valid at edges 0 and 1, rst_n low at edge 2 → out_valid stays 0, c=0x00000000. A new op at the first edge after release returns 4 cycles later.
- Gapped stream: in_valid pattern 1,0,0,1 → out_valid pattern 1,0,0,1 delayed by 4 edges; c holds its value across the gap.

Source files
------------

// File: rtl/fp_addsub_if.sv
// Streaming operand/result bundle for the binary32 add/sub stage.
// No backpressure: the producer drives in_valid freely, the consumer must accept out_valid.
interface fp_addsub_if;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        out_valid;
  logic [31:0] c;
  logic        ovf;
  logic        nan;
  logic        zero;

  modport master (
    output in_valid, a, b, sub,
    input  out_valid, c, ovf, nan, zero
  );

  modport slave (
    input  in_valid, a, b, sub,
    output out_valid, c, ovf, nan, zero
  );
endinterface

// File: rtl/fp_addsub.sv
// Pipelined binary32 adder/subtractor, denormals flushed; FPADD_RNE_EN selects RNE, else truncate.
// Latency 4 cycles, one op per cycle; no backpressure, results must be taken when out_valid is high.
// Outputs hold the last result while out_valid is low.
module fp_addsub (
  input  logic       clk,
  input  logic       rst_n,
  fp_addsub_if.slave io
);

`ifdef FPADD_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  typedef enum logic [1:0] {TAG_NONE, TAG_NAN, TAG_INF, TAG_ZERO} tag_t;

  // ---------------- input register ----------------
  logic        v0;
  logic [31:0] a0, b0;
  logic        sub0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0   <= 1'b0;
      a0   <= '0;
      b0   <= '0;
      sub0 <= 1'b0;
    end else begin
      v0 <= io.in_valid;
      if (io.in_valid) begin
        a0   <= io.a;
        b0   <= io.b;
        sub0 <= io.sub;
      end
    end
  end

  // ---------------- S1: unpack, classify, swap ----------------
  logic        sa, sb, a_nan, b_nan, a_inf, b_inf, swap;
  logic [7:0]  ea, eb;
  logic [23:0] ma, mb;
  tag_t        tag_n;
  logic        tsign_n;

  always_comb begin
    sa      = a0[31];
    sb      = b0[31] ^ sub0;
    ea      = a0[30:23];
    eb      = b0[30:23];
    ma      = (ea == 8'd0) ? 24'd0 : {1'b1, a0[22:0]};
    mb      = (eb == 8'd0) ? 24'd0 : {1'b1, b0[22:0]};
    a_nan   = (ea == 8'hFF) && (a0[22:0] != 23'd0);
    b_nan   = (eb == 8'hFF) && (b0[22:0] != 23'd0);
    a_inf   = (ea == 8'hFF) && (a0[22:0] == 23'd0);
    b_inf   = (eb == 8'hFF) && (b0[22:0] == 23'd0);
    swap    = (eb > ea) || ((eb == ea) && (mb > ma));
    tag_n   = TAG_NONE;
    tsign_n = 1'b0;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      tag_n = TAG_NAN;
    end else if (a_inf) begin
      tag_n   = TAG_INF;
      tsign_n = sa;
    end else if (b_inf) begin
      tag_n   = TAG_INF;
      tsign_n = sb;
    end else if ((ea == 8'd0) && (eb == 8'd0)) begin
      tag_n   = TAG_ZERO;
      tsign_n = sa & sb;
    end
  end

  logic        v1, tsign1, sign1, esub1;
  tag_t        tag1;
  logic [7:0]  el1, es1;
  logic [23:0] ml1, ms1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      tag1   <= TAG_NONE;
      tsign1 <= 1'b0;
      sign1  <= 1'b0;
      esub1  <= 1'b0;
      el1    <= '0;
      es1    <= '0;
      ml1    <= '0;
      ms1    <= '0;
    end else begin
      v1 <= v0;
      if (v0) begin
        tag1   <= tag_n;
        tsign1 <= tsign_n;
        sign1  <= swap ? sb : sa;
        esub1  <= sa ^ sb;
        el1    <= swap ? eb : ea;
        es1    <= swap ? ea : eb;
        ml1    <= swap ? mb : ma;
        ms1    <= swap ? ma : mb;
      end
    end
  end

  // ---------------- S2: align smaller operand ----------------
  logic [7:0]  d;
  logic [26:0] f, sh, mask, al;

  always_comb begin
    d    = el1 - es1;
    f    = {ms1, 3'b000};
    sh   = '0;
    mask = '0;
    if (d >= 8'd26) begin
      al = {26'd0, |ms1};
    end else begin
      mask = (27'd1 << d[4:0]) - 27'd1;
      sh   = f >> d[4:0];
      // Bits shifted past the LSB collapse into the sticky position.
      al   = {sh[26:1], sh[0] | (|(f & mask))};
    end
  end

  logic        v2, tsign2, sign2, esub2;
  tag_t        tag2;
  logic [7:0]  e2;
  logic [26:0] ml2, ms2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2     <= 1'b0;
      tag2   <= TAG_NONE;
      tsign2 <= 1'b0;
      sign2  <= 1'b0;
      esub2  <= 1'b0;
      e2     <= '0;
      ml2    <= '0;
      ms2    <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        tag2   <= tag1;
        tsign2 <= tsign1;
        sign2  <= sign1;
        esub2  <= esub1;
        e2     <= el1;
        ml2    <= {ml1, 3'b000};
        ms2    <= al;
      end
    end
  end

  // ---------------- S3: magnitude add/subtract ----------------
  logic [27:0] sum_n;
  assign sum_n = esub2 ? ({1'b0, ml2} - {1'b0, ms2}) : ({1'b0, ml2} + {1'b0, ms2});

  logic        v3, tsign3, sign3;
  tag_t        tag3;
  logic [7:0]  e3;
  logic [27:0] sum3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3     <= 1'b0;
      tag3   <= TAG_NONE;
      tsign3 <= 1'b0;
      sign3  <= 1'b0;
      e3     <= '0;
      sum3   <= '0;
    end else begin
      v3 <= v2;
      if (v2) begin
        tag3   <= tag2;
        tsign3 <= tsign2;
        sign3  <= sign2;
        e3     <= e2;
        sum3   <= sum_n;
      end
    end
  end

  // ---------------- S4: normalize, round, pack ----------------
  logic [4:0]  lz;
  logic [26:0] m27;
  logic [9:0]  en, er;
  logic        rup;
  logic [24:0] m25;
  logic [22:0] frac;
  logic [31:0] c_n;
  logic        ovf_n, nan_n, zero_n;

  always_comb begin
    lz = '0;
    for (int i = 0; i < 27; i++) begin
      if (sum3[i]) lz = 5'(26 - i);
    end
    if (sum3[27]) begin
      m27 = {sum3[27:2], |sum3[1:0]};
      en  = 10'(e3) + 10'd1;
    end else begin
      m27 = sum3[26:0] << lz;
      en  = 10'(e3) - 10'(lz);
    end
    rup = RNE & m27[2] & (m27[1] | m27[0] | m27[3]);
    m25 = {1'b0, m27[26:3]} + 25'(rup);
    // Rounding carry leaves 1.000..0, so renormalize by one place.
    if (m25[24]) begin
      frac = m25[23:1];
      er   = en + 10'd1;
    end else begin
      frac = m25[22:0];
      er   = en;
    end

    c_n    = {sign3, er[7:0], frac};
    ovf_n  = 1'b0;
    nan_n  = 1'b0;
    zero_n = 1'b0;
    case (tag3)
      TAG_NAN: begin
        c_n   = 32'h7FC0_0000;
        nan_n = 1'b1;
      end
      TAG_INF: c_n = {tsign3, 31'h7F80_0000};
      TAG_ZERO: begin
        c_n    = {tsign3, 31'd0};
        zero_n = 1'b1;
      end
      default: begin
        if (sum3 == 28'd0) begin
          c_n    = 32'd0;
          zero_n = 1'b1;
        end else if ($signed(er) >= 10'sd255) begin
          c_n   = {sign3, 31'h7F80_0000};
          ovf_n = 1'b1;
        end else if ($signed(er) <= 10'sd0) begin
          c_n    = {sign3, 31'd0};
          zero_n = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io.out_valid <= 1'b0;
      io.c         <= '0;
      io.ovf       <= 1'b0;
      io.nan       <= 1'b0;
      io.zero      <= 1'b0;
    end else begin
      io.out_valid <= v3;
      if (v3) begin
        io.c    <= c_n;
        io.ovf  <= ovf_n;
        io.nan  <= nan_n;
        io.zero <= zero_n;
      end
    end
  end

endmodule
